// File: rtl/jtkicker_pkg.sv
// Shared types and defaults for the kicker ROM arbiter.
package jtkicker_pkg;

  // Which requester owns the SDRAM transaction in flight.
  typedef enum logic {
    GNT_SCR = 1'b0,
    GNT_OBJ = 1'b1
  } grantee_e;

  // Arbiter sequencing: pick a miss, wait for the controller to accept, wait for data.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_e;

  localparam int              DEF_SCR_AW     = 13;
  localparam int              DEF_OBJ_AW     = 14;
  localparam int              DEF_SDRAM_AW   = 22;
  localparam logic [21:0]     DEF_SCR_OFFSET = 22'h0;
  localparam logic [21:0]     DEF_OBJ_OFFSET = 22'h2000;

  // When both sides miss, serve whoever was not served last so neither starves.
  function automatic grantee_e pick_grantee(input logic miss_scr, input logic miss_obj,
                                            input grantee_e last);
    grantee_e g;
    if (miss_scr && miss_obj) begin
      if (last == GNT_SCR) g = GNT_OBJ;
      else                 g = GNT_SCR;
    end else if (miss_obj) begin
      g = GNT_OBJ;
    end else begin
      g = GNT_SCR;
    end
    return g;
  endfunction

endpackage

// File: rtl/jtkicker_romarb_slot.sv
// One requester's word buffer: latched address, valid flag, data, hit and miss detection.
module jtkicker_romarb_slot
  import jtkicker_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          busy,
  input  logic [AW-1:0] inflight_addr,
  input  logic          load,
  input  logic [31:0]   din,
  output logic [31:0]   data,
  output logic          ok,
  output logic          miss
);

  logic [AW-1:0] lat;
  logic          v;

  // ok compares against the live address so a stale word is never flagged, even for one cycle.
  assign ok   = cs & v & (addr == lat);
  // A fetch already under way for this exact address is not a new miss.
  assign miss = cs & ~ok & ~(busy & (addr == inflight_addr));

  // Accept returning data only if the requester still wants the address that was fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data buffer is reset along with lat/v; it is a single word, and clearing it
    // keeps outputs deterministic out of reset instead of relying on ok to mask X.
    if (!rst_n) begin
      lat  <= '0;
      v    <= 1'b0;
      data <= '0;
    end else if (load && cs && (addr == inflight_addr)) begin
      // NOTE: non-blocking so lat, v and data all update from pre-edge values together.
      data <= din;
      lat  <= inflight_addr;
      v    <= 1'b1;
    end
  end

endmodule

// File: rtl/jtkicker_romarb.sv
// Shares one SDRAM read port between the scroll and object ROM fetchers.
module jtkicker_romarb
  import jtkicker_pkg::*;
#(
  parameter int                  SCR_AW     = DEF_SCR_AW,
  parameter int                  OBJ_AW     = DEF_OBJ_AW,
  parameter int                  SDRAM_AW   = DEF_SDRAM_AW,
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET = DEF_SCR_OFFSET,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET = DEF_OBJ_OFFSET
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SCR_AW-1:0]   scr_addr,
  output logic [31:0]         scr_data,
  output logic                scr_ok,
  input  logic                obj_cs,
  input  logic [OBJ_AW-1:0]   obj_addr,
  output logic [31:0]         obj_data,
  output logic                obj_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_dst,
  input  logic [31:0]         sdram_data
);

  // Wide enough to hold either requester's address.
  localparam int IA_W = (SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW;

  state_e              state;
  grantee_e            gnt;
  grantee_e            last_grant;
  grantee_e            next_gnt;
  logic [IA_W-1:0]     inflight_addr;
  logic                miss_scr;
  logic                miss_obj;
  logic                load;
  logic                scr_busy;
  logic                obj_busy;
  logic [SDRAM_AW-1:0] scr_req_addr;
  logic [SDRAM_AW-1:0] obj_req_addr;

  assign scr_busy = (state != IDLE) && (gnt == GNT_SCR);
  assign obj_busy = (state != IDLE) && (gnt == GNT_OBJ);
  // ack and dst together in WAIT_ACK behave as ack then dst: the data is still taken.
  assign load     = ((state == WAIT_DATA) && sdram_dst) ||
                    ((state == WAIT_ACK) && sdram_ack && sdram_dst);
  assign next_gnt = pick_grantee(miss_scr, miss_obj, last_grant);

  // Region offset wraps silently modulo the SDRAM address space.
  assign scr_req_addr = SDRAM_AW'(scr_addr) + SCR_OFFSET;
  assign obj_req_addr = SDRAM_AW'(obj_addr) + OBJ_OFFSET;

  jtkicker_romarb_slot #(.AW(SCR_AW)) u_scr (
    .clk           (clk),
    .rst_n         (rst_n),
    .cs            (1'b1),
    .addr          (scr_addr),
    .busy          (scr_busy),
    .inflight_addr (inflight_addr[SCR_AW-1:0]),
    .load          (load && (gnt == GNT_SCR)),
    .din           (sdram_data),
    .data          (scr_data),
    .ok            (scr_ok),
    .miss          (miss_scr)
  );

  jtkicker_romarb_slot #(.AW(OBJ_AW)) u_obj (
    .clk           (clk),
    .rst_n         (rst_n),
    .cs            (obj_cs),
    .addr          (obj_addr),
    .busy          (obj_busy),
    .inflight_addr (inflight_addr[OBJ_AW-1:0]),
    .load          (load && (gnt == GNT_OBJ)),
    .din           (sdram_data),
    .data          (obj_data),
    .ok            (obj_ok),
    .miss          (miss_obj)
  );

  // Request sequencer: grant a miss, hold the request until ack, then wait for the data strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sdram_req     <= 1'b0;
      sdram_addr    <= '0;
      inflight_addr <= '0;
      gnt           <= GNT_SCR;
      last_grant    <= GNT_OBJ;
    end else begin
      case (state)
        IDLE: begin
          // A stray dst here is ignored: only the miss lines matter.
          if (miss_scr || miss_obj) begin
            gnt        <= next_gnt;
            last_grant <= next_gnt;
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
            if (next_gnt == GNT_OBJ) begin
              sdram_addr    <= obj_req_addr;
              inflight_addr <= IA_W'(obj_addr);
            end else begin
              sdram_addr    <= scr_req_addr;
              inflight_addr <= IA_W'(scr_addr);
            end
          end
        end
        WAIT_ACK: begin
          // Request stays up even if the requester moves on; the stale data is dropped later.
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (sdram_dst) state <= IDLE;
            else           state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (sdram_dst) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          sdram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtkicker_romarb.sv
// Self-checking bench for jtkicker_romarb: directed scenarios plus a randomized run
// checked against a transaction-level model of the word buffers.
module tb_jtkicker_romarb;

  localparam logic [21:0] SCR_OFF = 22'h0;
  localparam logic [21:0] OBJ_OFF = 22'h2000;

  logic        clk;
  logic        rst_n;
  logic [12:0] scr_addr;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs;
  logic [13:0] obj_addr;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_dst;
  logic [31:0] sdram_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [12:0] scr_pool [4] = '{13'h0010, 13'h0011, 13'h1FFF, 13'h0000};
  logic [13:0] obj_pool [4] = '{14'h0000, 14'h0001, 14'h3FFF, 14'h0005};

  jtkicker_romarb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_data (sdram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Wait (bounded) for a request and return its address.
  task automatic wait_req(output logic [21:0] a);
    int i;
    i = 0;
    while (sdram_req !== 1'b1 && i < 30) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (sdram_req !== 1'b1) begin n_bad++; $display("FAIL req_timeout got=%b exp=1", sdram_req); end
    a = sdram_addr;
  endtask

  task automatic pulse_ack(input int dly);
    repeat (dly) @(negedge clk);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
  endtask

  task automatic pulse_dst(input int dly, input logic [31:0] d);
    repeat (dly) @(negedge clk);
    sdram_dst  = 1'b1;
    sdram_data = d;
    @(negedge clk);
    sdram_dst  = 1'b0;
  endtask

  // Count cycles with a request raised over the next n cycles.
  task automatic quiet_cycles(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sdram_req === 1'b1) hits++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; scr_addr = 13'h0100; obj_cs = 1'b0; obj_addr = '0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = '0;
    #12;
    n_cmp++; if (sdram_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", sdram_req); end
    n_cmp++; if (sdram_addr !== 22'h0) begin n_bad++; $display("FAIL rst_addr got=%h exp=0", sdram_addr); end
    n_cmp++; if (scr_data !== 32'h0) begin n_bad++; $display("FAIL rst_scr_data got=%h exp=0", scr_data); end
    n_cmp++; if (obj_data !== 32'h0) begin n_bad++; $display("FAIL rst_obj_data got=%h exp=0", obj_data); end
    n_cmp++; if (scr_ok !== 1'b0) begin n_bad++; $display("FAIL rst_scr_ok got=%b exp=0", scr_ok); end
    n_cmp++; if (obj_ok !== 1'b0) begin n_bad++; $display("FAIL rst_obj_ok got=%b exp=0", obj_ok); end
  endtask

  task automatic test_scr_fetch;
    logic [21:0] a;
    int hits;
    @(negedge clk);
    rst_n = 1'b1;
    wait_req(a);
    n_cmp++; if (a !== 22'h000100) begin n_bad++; $display("FAIL fetch_addr got=%h exp=000100", a); end
    pulse_ack(2);
    n_cmp++; if (sdram_req !== 1'b0) begin n_bad++; $display("FAIL fetch_req_drop got=%b exp=0", sdram_req); end
    n_cmp++; if (scr_ok !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ok got=%b exp=0", scr_ok); end
    pulse_dst(3, 32'hDEADBEEF);
    n_cmp++; if (scr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_data got=%h exp=deadbeef", scr_data); end
    n_cmp++; if (scr_ok !== 1'b1) begin n_bad++; $display("FAIL fetch_ok got=%b exp=1", scr_ok); end
    quiet_cycles(6, hits);
    n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL fetch_no_more_req got=%0d exp=0", hits); end
  endtask

  task automatic test_addr_change;
    logic [31:0] d;
    d = $urandom;
    scr_addr = 13'h0101;
    #1;
    n_cmp++; if (scr_ok !== 1'b0) begin n_bad++; $display("FAIL chg_ok_same_cycle got=%b exp=0", scr_ok); end
    @(negedge clk);
    n_cmp++; if (sdram_req !== 1'b1) begin n_bad++; $display("FAIL chg_req got=%b exp=1", sdram_req); end
    n_cmp++; if (sdram_addr !== 22'h000101) begin n_bad++; $display("FAIL chg_addr got=%h exp=000101", sdram_addr); end
    pulse_ack(1);
    pulse_dst(1, d);
    n_cmp++; if (scr_data !== d) begin n_bad++; $display("FAIL chg_data got=%h exp=%h", scr_data, d); end
    n_cmp++; if (scr_ok !== 1'b1) begin n_bad++; $display("FAIL chg_ok got=%b exp=1", scr_ok); end
  endtask

  task automatic test_alternate(output logic [31:0] d_obj, output logic [31:0] d_scr);
    logic [21:0] a;
    logic [31:0] d1, d2;
    // Round 1: last grant was scroll, so object goes first.
    d1 = $urandom; d2 = $urandom;
    scr_addr = 13'h0102; obj_cs = 1'b1; obj_addr = 14'h0005;
    wait_req(a);
    n_cmp++; if (a !== 22'h002005) begin n_bad++; $display("FAIL alt1_first got=%h exp=002005", a); end
    pulse_ack(0); pulse_dst(0, d1);
    wait_req(a);
    n_cmp++; if (a !== 22'h000102) begin n_bad++; $display("FAIL alt1_second got=%h exp=000102", a); end
    pulse_ack(1); pulse_dst(2, d2);
    n_cmp++; if (obj_data !== d1 || obj_ok !== 1'b1) begin n_bad++; $display("FAIL alt1_obj got=%h/%b exp=%h/1", obj_data, obj_ok, d1); end
    n_cmp++; if (scr_data !== d2 || scr_ok !== 1'b1) begin n_bad++; $display("FAIL alt1_scr got=%h/%b exp=%h/1", scr_data, scr_ok, d2); end
    // Round 2: scroll was served last, so object leads again.
    d1 = $urandom; d2 = $urandom;
    scr_addr = 13'h0103; obj_addr = 14'h0008;
    wait_req(a);
    n_cmp++; if (a !== 22'h002008) begin n_bad++; $display("FAIL alt2_first got=%h exp=002008", a); end
    pulse_ack(1); pulse_dst(1, d1);
    wait_req(a);
    n_cmp++; if (a !== 22'h000103) begin n_bad++; $display("FAIL alt2_second got=%h exp=000103", a); end
    pulse_ack(0); pulse_dst(1, d2);
    n_cmp++; if (obj_data !== d1 || obj_ok !== 1'b1) begin n_bad++; $display("FAIL alt2_obj got=%h/%b exp=%h/1", obj_data, obj_ok, d1); end
    n_cmp++; if (scr_data !== d2 || scr_ok !== 1'b1) begin n_bad++; $display("FAIL alt2_scr got=%h/%b exp=%h/1", scr_data, scr_ok, d2); end
    d_obj = d1; d_scr = d2;
  endtask

  task automatic test_discard(input logic [31:0] d_prev, output logic [31:0] d_new);
    logic [21:0] a;
    logic [31:0] d;
    d = $urandom;
    obj_addr = 14'h0006;
    wait_req(a);
    n_cmp++; if (a !== 22'h002006) begin n_bad++; $display("FAIL disc_addr got=%h exp=002006", a); end
    pulse_ack(0);
    obj_addr = 14'h0007;
    pulse_dst(1, 32'h12345678);
    n_cmp++; if (obj_data !== d_prev) begin n_bad++; $display("FAIL disc_data got=%h exp=%h", obj_data, d_prev); end
    n_cmp++; if (obj_ok !== 1'b0) begin n_bad++; $display("FAIL disc_ok got=%b exp=0", obj_ok); end
    @(negedge clk);
    n_cmp++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h002007) begin n_bad++; $display("FAIL disc_rereq got=%b/%h exp=1/002007", sdram_req, sdram_addr); end
    pulse_ack(0); pulse_dst(0, d);
    n_cmp++; if (obj_data !== d || obj_ok !== 1'b1) begin n_bad++; $display("FAIL disc_refetch got=%h/%b exp=%h/1", obj_data, obj_ok, d); end
    d_new = d;
  endtask

  task automatic test_obj_cs(input logic [31:0] d_obj);
    int hits;
    obj_cs = 1'b0; obj_addr = 14'h0033;
    #1;
    n_cmp++; if (obj_ok !== 1'b0) begin n_bad++; $display("FAIL cs_off_ok got=%b exp=0", obj_ok); end
    quiet_cycles(5, hits);
    n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL cs_off_req got=%0d exp=0", hits); end
    obj_cs = 1'b1; obj_addr = 14'h0007;
    #1;
    n_cmp++; if (obj_ok !== 1'b1 || obj_data !== d_obj) begin n_bad++; $display("FAIL cs_hit got=%b/%h exp=1/%h", obj_ok, obj_data, d_obj); end
    quiet_cycles(4, hits);
    n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL cs_hit_req got=%0d exp=0", hits); end
  endtask

  task automatic test_boundary(input logic [31:0] d_scr, input logic [31:0] d_obj);
    logic [21:0] a;
    logic [31:0] d;
    int hits;
    // Data strobe with nothing outstanding changes nothing.
    sdram_dst = 1'b1; sdram_data = 32'hBADC0DE5;
    @(negedge clk);
    sdram_dst = 1'b0;
    n_cmp++; if (scr_data !== d_scr || scr_ok !== 1'b1) begin n_bad++; $display("FAIL idle_dst_scr got=%h/%b exp=%h/1", scr_data, scr_ok, d_scr); end
    n_cmp++; if (obj_data !== d_obj || obj_ok !== 1'b1) begin n_bad++; $display("FAIL idle_dst_obj got=%h/%b exp=%h/1", obj_data, obj_ok, d_obj); end
    n_cmp++; if (sdram_req !== 1'b0) begin n_bad++; $display("FAIL idle_dst_req got=%b exp=0", sdram_req); end
    // Highest scroll address, ack and dst in the same cycle.
    d = $urandom;
    scr_addr = 13'h1FFF;
    wait_req(a);
    n_cmp++; if (a !== 22'h001FFF) begin n_bad++; $display("FAIL ackdst_addr got=%h exp=001fff", a); end
    sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = d;
    @(negedge clk);
    sdram_ack = 1'b0; sdram_dst = 1'b0;
    n_cmp++; if (scr_data !== d || scr_ok !== 1'b1) begin n_bad++; $display("FAIL ackdst_data got=%h/%b exp=%h/1", scr_data, scr_ok, d); end
    quiet_cycles(3, hits);
    n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL ackdst_no_req got=%0d exp=0", hits); end
    // Highest object address lands at the top of the object region.
    d = $urandom;
    obj_addr = 14'h3FFF;
    wait_req(a);
    n_cmp++; if (a !== 22'h005FFF) begin n_bad++; $display("FAIL objtop_addr got=%h exp=005fff", a); end
    pulse_ack(2); pulse_dst(0, d);
    n_cmp++; if (obj_data !== d || obj_ok !== 1'b1) begin n_bad++; $display("FAIL objtop_data got=%h/%b exp=%h/1", obj_data, obj_ok, d); end
  endtask

  task automatic test_reset_mid;
    logic [21:0] a;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    scr_addr = 13'h0200;
    wait_req(a);
    n_cmp++; if (a !== 22'h000200) begin n_bad++; $display("FAIL rmid_addr got=%h exp=000200", a); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (sdram_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req got=%b exp=0", sdram_req); end
    n_cmp++; if (scr_ok !== 1'b0 || obj_ok !== 1'b0) begin n_bad++; $display("FAIL rmid_ok got=%b%b exp=00", scr_ok, obj_ok); end
    @(negedge clk);
    rst_n = 1'b1;
    // Both miss after reset; last grant resets to object, so scroll goes first.
    wait_req(a);
    n_cmp++; if (a !== 22'h000200) begin n_bad++; $display("FAIL rmid_rereq got=%h exp=000200", a); end
    pulse_ack(1); pulse_dst(1, d1);
    wait_req(a);
    n_cmp++; if (a !== 22'h005FFF) begin n_bad++; $display("FAIL rmid_obj got=%h exp=005fff", a); end
    pulse_ack(0); pulse_dst(2, d2);
    n_cmp++; if (scr_data !== d1 || scr_ok !== 1'b1) begin n_bad++; $display("FAIL rmid_scr_data got=%h/%b exp=%h/1", scr_data, scr_ok, d1); end
    n_cmp++; if (obj_data !== d2 || obj_ok !== 1'b1) begin n_bad++; $display("FAIL rmid_obj_data got=%h/%b exp=%h/1", obj_data, obj_ok, d2); end
  endtask

  // Randomized traffic against a model of "each requester keeps the last word fetched
  // for the address it still wants".
  task automatic test_random;
    bit          m_v [2];
    logic [13:0] m_lat [2];
    logic [31:0] m_data [2];
    bit          r_busy, r_acked, dst_txn, exp_ok_s, exp_ok_o, good_s, good_o;
    int          r_cnt, n_req;
    logic [21:0] txn_addr;
    logic [31:0] txn_data;
    m_v = '{0, 0}; m_lat = '{14'h0, 14'h0}; m_data = '{32'h0, 32'h0};
    r_busy = 0; r_acked = 0; dst_txn = 0; r_cnt = 0; n_req = 0;
    txn_addr = '0; txn_data = '0;
    @(negedge clk);
    rst_n = 1'b0; sdram_ack = 1'b0; sdram_dst = 1'b0;
    scr_addr = scr_pool[0]; obj_addr = obj_pool[0]; obj_cs = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      // Retire the data strobe seen at the last edge.
      if (dst_txn) begin
        if (txn_addr < OBJ_OFF) begin
          if (scr_addr == 13'(txn_addr - SCR_OFF)) begin
            m_v[0] = 1; m_lat[0] = 14'(scr_addr); m_data[0] = txn_data;
          end
        end else if (obj_cs && obj_addr == 14'(txn_addr - OBJ_OFF)) begin
          m_v[1] = 1; m_lat[1] = obj_addr; m_data[1] = txn_data;
        end
        dst_txn = 0;
      end
      exp_ok_s = m_v[0] && (scr_addr == m_lat[0][12:0]);
      exp_ok_o = obj_cs && m_v[1] && (obj_addr == m_lat[1]);
      n_cmp++; if (scr_ok !== exp_ok_s) begin n_bad++; $display("FAIL rnd_scr_ok cyc=%0d got=%b exp=%b", cyc, scr_ok, exp_ok_s); end
      n_cmp++; if (obj_ok !== exp_ok_o) begin n_bad++; $display("FAIL rnd_obj_ok cyc=%0d got=%b exp=%b", cyc, obj_ok, exp_ok_o); end
      n_cmp++; if (scr_data !== m_data[0]) begin n_bad++; $display("FAIL rnd_scr_data cyc=%0d got=%h exp=%h", cyc, scr_data, m_data[0]); end
      n_cmp++; if (obj_data !== m_data[1]) begin n_bad++; $display("FAIL rnd_obj_data cyc=%0d got=%h exp=%h", cyc, obj_data, m_data[1]); end
      // A fresh request must target a requester that is actually missing.
      if (sdram_req === 1'b1 && !r_busy) begin
        good_s = !exp_ok_s && (sdram_addr == SCR_OFF + 22'(scr_addr));
        good_o = obj_cs && !exp_ok_o && (sdram_addr == OBJ_OFF + 22'(obj_addr));
        n_cmp++; if (!(good_s || good_o)) begin n_bad++; $display("FAIL rnd_req_target cyc=%0d got=%h exp=missing requester", cyc, sdram_addr); end
        n_req++;
        r_busy = 1; r_acked = 0; r_cnt = $urandom_range(0, 3); txn_addr = sdram_addr;
      end
      // SDRAM controller stand-in.
      sdram_ack = 1'b0; sdram_dst = 1'b0;
      if (r_busy && !r_acked) begin
        if (r_cnt == 0) begin
          sdram_ack = 1'b1; r_acked = 1;
          if ($urandom_range(0, 3) == 0) begin
            txn_data = $urandom; sdram_dst = 1'b1; sdram_data = txn_data;
            r_busy = 0; dst_txn = 1;
          end else begin
            r_cnt = $urandom_range(0, 4);
          end
        end else begin
          r_cnt--;
        end
      end else if (r_busy && r_acked) begin
        if (r_cnt == 0) begin
          txn_data = $urandom; sdram_dst = 1'b1; sdram_data = txn_data;
          r_busy = 0; dst_txn = 1;
        end else begin
          r_cnt--;
        end
      end else if (sdram_req !== 1'b1 && $urandom_range(0, 9) == 0) begin
        sdram_dst = 1'b1; sdram_data = $urandom;
      end
      // Requester stimulus.
      if ($urandom_range(0, 3) == 0) scr_addr = scr_pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) obj_addr = obj_pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) obj_cs = ~obj_cs;
    end
    sdram_ack = 1'b0; sdram_dst = 1'b0;
    n_cmp++; if (n_req < 20) begin n_bad++; $display("FAIL rnd_activity got=%0d exp=>=20", n_req); end
  endtask

  initial begin
    logic [31:0] d_obj, d_scr, d_obj2;
    test_reset;
    test_scr_fetch;
    test_addr_change;
    test_alternate(d_obj, d_scr);
    test_discard(d_obj, d_obj2);
    test_obj_cs(d_obj2);
    test_boundary(d_scr, d_obj2);
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
